// File: rtl/hynoc_pkg.sv
// Shared NoC definitions: flit framing states and FIFO word layout helpers.
package hynoc_pkg;

  typedef enum logic [0:0] {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } frame_state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // The last-flit flag sits directly above the payload in every FIFO word.
  function automatic int unsigned flit_last_pos(input int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid2.sv
// Two-entry in-order buffer: slot0 is the head, slot1 shifts into slot0 on pop.
// Writes land in slot (occ - pop) so a same-cycle pop and write never bubble.
module stream_skid2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0_r, slot1_r;
  logic [WIDTH-1:0] slot0_n, slot1_n;
  logic [1:0]       occ_r, occ_n, wr_slot_s;

  // Next buffer contents and occupancy.
  always_comb begin
    slot0_n   = slot0_r;
    slot1_n   = slot1_r;
    wr_slot_s = occ_r - {1'b0, pop};
    occ_n     = occ_r + {1'b0, wr_en} - {1'b0, pop};
    if (pop) begin
      slot0_n = slot1_r;
    end else begin
      slot0_n = slot0_r;
    end
    if (wr_en) begin
      if (wr_slot_s == 2'd0) begin
        slot0_n = wr_data;
      end else begin
        slot1_n = wr_data;
      end
    end else begin
      slot1_n = slot1_r;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      slot0_r <= {WIDTH{1'b0}};
      slot1_r <= {WIDTH{1'b0}};
      occ_r   <= 2'd0;
    end else begin
      slot0_r <= slot0_n;
      slot1_r <= slot1_n;
      occ_r   <= occ_n;
    end
  end

  assign occ  = occ_r;
  assign head = slot0_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency LUT FIFO into a framed valid/ready flit stream,
// counting delivered packets and flagging packets that exceed the length limit.
module fifo_stream_reader
  import hynoc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_PKT_FLITS = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH:0]   fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  err_len
);

  localparam int unsigned      LAST_POS = flit_last_pos(DATA_WIDTH);
  localparam int unsigned      IDX_W    = $clog2(MAX_PKT_FLITS);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_PKT_FLITS - 1);

  frame_state_e         state_r, state_n;
  logic [IDX_W-1:0]     idx_r, idx_n;
  logic                 rd_pend_r;
  logic [CNT_WIDTH-1:0] pkt_count_r;
  logic                 err_len_r, err_n;
  logic                 tail_pop_s, pop_s, last_s;
  logic [1:0]           occ_s;
  logic [DATA_WIDTH:0]  head_s;
  logic [2:0]           inflight_s;

  stream_skid2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .srst    (srst),
    .wr_en   (rd_pend_r),
    .wr_data (fifo_rdata),
    .pop     (pop_s),
    .occ     (occ_s),
    .head    (head_s)
  );

  assign out_valid = (occ_s != 2'd0);
  assign pop_s     = out_valid & out_ready;
  assign last_s    = head_s[LAST_POS];
  assign out_data  = head_s[DATA_WIDTH-1:0];
  assign out_last  = last_s;
  assign out_first = (state_r == ST_HEAD);
  assign pkt_count = pkt_count_r;
  assign err_len   = err_len_r;

  // Counting the in-flight read keeps buffered + pending words at or below two.
  assign inflight_s = {1'b0, occ_s} + {2'b00, rd_pend_r} - {2'b00, pop_s};
  assign fifo_ren   = ~srst & ~fifo_rempty & (inflight_s < 3'd2);

  // Framing next-state: only a handshake moves the packet position.
  always_comb begin
    state_n    = state_r;
    idx_n      = idx_r;
    err_n      = 1'b0;
    tail_pop_s = 1'b0;
    case (state_r)
      ST_HEAD: begin
        if (pop_s && last_s) begin
          tail_pop_s = 1'b1;
        end else if (pop_s) begin
          state_n = ST_BODY;
          idx_n   = IDX_ONE;
        end else begin
          state_n = ST_HEAD;
        end
      end
      ST_BODY: begin
        if (pop_s && last_s) begin
          state_n    = ST_HEAD;
          idx_n      = IDX_ZERO;
          tail_pop_s = 1'b1;
        end else if (pop_s && (idx_r == IDX_LAST)) begin
          state_n = ST_HEAD;
          idx_n   = IDX_ZERO;
          err_n   = 1'b1;
        end else if (pop_s) begin
          idx_n = idx_r + IDX_ONE;
        end else begin
          state_n = ST_BODY;
        end
      end
      default: begin
        state_n = ST_HEAD;
        idx_n   = IDX_ZERO;
      end
    endcase
  end

  // Framing, read-pending, counter and error registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r     <= ST_HEAD;
      idx_r       <= IDX_ZERO;
      rd_pend_r   <= 1'b0;
      pkt_count_r <= {CNT_WIDTH{1'b0}};
      err_len_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      rd_pend_r   <= fifo_ren;
      pkt_count_r <= pkt_count_r + {{(CNT_WIDTH-1){1'b0}}, tail_pop_s};
      err_len_r   <= err_n;
    end
  end

endmodule
